// File: rtl/axis_lane_adder.sv
// axis_lane_adder: per-lane add/subtract AXI-Stream stage with a
// two-entry skid buffer, registered tready and debug beat/packet counters.
module axis_lane_adder #(
    parameter int          DATA_W    = 512,
    parameter int          LANE_W    = 32,
    parameter logic [31:0] ADD_CONST = 32'hDEADBEEF,
    parameter int          CNT_W     = 32
) (
    input  logic              clk50mhz_0,
    input  logic              peripheral_reset_0,
    input  logic [DATA_W-1:0] AXI_STR_TXD_0_tdata,
    input  logic              AXI_STR_TXD_0_tlast,
    input  logic              AXI_STR_TXD_0_tvalid,
    output logic              AXI_STR_TXD_0_tready,
    output logic [DATA_W-1:0] AXI_STR_RXD_0_tdata,
    output logic              AXI_STR_RXD_0_tlast,
    output logic              AXI_STR_RXD_0_tvalid,
    input  logic              AXI_STR_RXD_0_tready,
    input  logic [1:0]        mode,
    output logic [CNT_W-1:0]  beat_count,
    output logic [CNT_W-1:0]  pkt_count
);

    localparam int NLANES = DATA_W / LANE_W;
    localparam logic [LANE_W-1:0] KC = LANE_W'(ADD_CONST);

    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic              skid_last_q, skid_last_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              ready_q, ready_d;
    logic [1:0]        mode_q, mode_d;
    logic              first_q, first_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]  pkt_q, pkt_d;

    logic              in_hs;
    logic              out_hs;
    logic [1:0]        eff_mode;
    logic [DATA_W-1:0] xdata;

    assign in_hs    = AXI_STR_TXD_0_tvalid && ready_q;
    assign out_hs   = out_valid_q && AXI_STR_RXD_0_tready;
    assign eff_mode = first_q ? mode : mode_q;

    // Lane-wise transform of the incoming beat; lanes never carry into each other.
    always_comb begin
        xdata = '0;
        for (int k = 0; k < NLANES; k++) begin
            unique case (eff_mode)
                2'd0: xdata[k*LANE_W +: LANE_W] = AXI_STR_TXD_0_tdata[k*LANE_W +: LANE_W];
                2'd1: xdata[k*LANE_W +: LANE_W] = AXI_STR_TXD_0_tdata[k*LANE_W +: LANE_W] + KC;
                2'd2: xdata[k*LANE_W +: LANE_W] = AXI_STR_TXD_0_tdata[k*LANE_W +: LANE_W]
                                                  + LANE_W'(2 * k);
                2'd3: xdata[k*LANE_W +: LANE_W] = AXI_STR_TXD_0_tdata[k*LANE_W +: LANE_W] - KC;
                default: xdata[k*LANE_W +: LANE_W] = AXI_STR_TXD_0_tdata[k*LANE_W +: LANE_W];
            endcase
        end
    end

    // Skid/output register steering, packet mode latch and counters.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        skid_data_d  = skid_data_q;
        mode_d       = mode_q;
        first_d      = first_q;
        beat_d       = beat_q;
        pkt_d        = pkt_q;

        if (!out_valid_q || out_hs) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_last_d   = skid_last_q;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_hs) begin
                out_valid_d = 1'b1;
                out_last_d  = AXI_STR_TXD_0_tlast;
                out_data_d  = xdata;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_hs) begin
            skid_valid_d = 1'b1;
            skid_last_d  = AXI_STR_TXD_0_tlast;
            skid_data_d  = xdata;
        end

        if (in_hs) begin
            if (first_q) begin
                mode_d = mode;
            end
            first_d = AXI_STR_TXD_0_tlast;
        end

        if (out_hs) begin
            beat_d = beat_q + 1'b1;
            if (out_last_q) begin
                pkt_d = pkt_q + 1'b1;
            end
        end

        ready_d = !skid_valid_d;
    end

    // State registers with synchronous reset discarding any in-flight beats.
    always_ff @(posedge clk50mhz_0) begin
        if (peripheral_reset_0) begin
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
            mode_q       <= 2'd0;
            first_q      <= 1'b1;
            beat_q       <= '0;
            pkt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
            mode_q       <= mode_d;
            first_q      <= first_d;
            beat_q       <= beat_d;
            pkt_q        <= pkt_d;
        end
    end

    assign AXI_STR_TXD_0_tready = ready_q;
    assign AXI_STR_RXD_0_tdata  = out_data_q;
    assign AXI_STR_RXD_0_tlast  = out_last_q;
    assign AXI_STR_RXD_0_tvalid = out_valid_q;
    assign beat_count           = beat_q;
    assign pkt_count            = pkt_q;

endmodule

// File: tb/tb_axis_lane_adder.sv
// tb_axis_lane_adder: directed and random stimulus with a queue-based
// scoreboard checking data, tlast, handshakes and counters.
module tb_axis_lane_adder;

    localparam int DW = 512;
    localparam int LW = 32;
    localparam int NL = DW / LW;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] txd_data;
    logic          txd_last;
    logic          txd_valid;
    logic          txd_ready;
    logic [DW-1:0] rxd_data;
    logic          rxd_last;
    logic          rxd_valid;
    logic          rxd_ready;
    logic [1:0]    mode;
    logic [31:0]   beat_count;
    logic [31:0]   pkt_count;

    beat_t q[$];
    beat_t mon_e;
    int    n_assert = 0;
    int    n_fail = 0;
    int    exp_beats = 0;
    int    exp_pkts = 0;
    logic  m_first = 1'b1;
    logic [1:0] m_mode = 2'd0;
    logic  chk_ready = 1'b0;

    always #5 clk = ~clk;

    axis_lane_adder dut (
        .clk50mhz_0           (clk),
        .peripheral_reset_0   (rst),
        .AXI_STR_TXD_0_tdata  (txd_data),
        .AXI_STR_TXD_0_tlast  (txd_last),
        .AXI_STR_TXD_0_tvalid (txd_valid),
        .AXI_STR_TXD_0_tready (txd_ready),
        .AXI_STR_RXD_0_tdata  (rxd_data),
        .AXI_STR_RXD_0_tlast  (rxd_last),
        .AXI_STR_RXD_0_tvalid (rxd_valid),
        .AXI_STR_RXD_0_tready (rxd_ready),
        .mode                 (mode),
        .beat_count           (beat_count),
        .pkt_count            (pkt_count)
    );

    function automatic logic [DW-1:0] xform(logic [DW-1:0] d, logic [1:0] m);
        logic [DW-1:0] r;
        logic [LW-1:0] x;
        r = '0;
        for (int k = 0; k < NL; k++) begin
            x = d[k*LW +: LW];
            case (m)
                2'd0: x = x;
                2'd1: x = x + 32'hDEADBEEF;
                2'd2: x = x + LW'(2 * k);
                default: x = x - 32'hDEADBEEF;
            endcase
            r[k*LW +: LW] = x;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_first   = 1'b1;
        m_mode    = 2'd0;
        exp_beats = 0;
        exp_pkts  = 0;
    endtask

    // Drives one cycle starting at posedge+1; returns at the next posedge+1.
    task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic l,
                               input logic r, output logic acc);
        logic t0;
        logic [1:0] em;
        txd_valid = v;
        txd_data  = d;
        txd_last  = l;
        rxd_ready = r;
        t0 = txd_ready;
        @(negedge clk);
        if (chk_ready) chk("tready_comb", txd_ready, t0);
        acc = v && txd_ready;
        if (acc) begin
            em = m_first ? mode : m_mode;
            q.push_back(beat_t'({l, xform(d, em)}));
            if (m_first) m_mode = mode;
            m_first = l;
            exp_beats++;
            if (l) exp_pkts++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            drive_cycle(1'b1, d, l, 1'b1, acc);
            n++;
        end
        if (!acc) chk("send_timeout", acc, 1);
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) drive_cycle(1'b0, '0, 1'b0, 1'b1, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 40) begin
            idle(1);
            n++;
        end
        idle(1);
        chk("drain_empty", q.size(), 0);
        chk("beat_count", beat_count, exp_beats);
        chk("pkt_count", pkt_count, exp_pkts);
    endtask

    // Output monitor: every RXD handshake pops and checks one expected beat.
    always @(negedge clk) begin
        if (!rst && rxd_valid && rxd_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", q.size(), 1);
            end else begin
                mon_e = q.pop_front();
                chk("out_data", rxd_data, mon_e.data);
                chk("out_last", rxd_last, mon_e.last);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        logic [DW-1:0] d;
        logic l;
        logic v;
        logic r;
        int sent;
        int acc_low;
        int cyc;
        int base;

        rst = 1'b1;
        txd_valid = 1'b0;
        txd_data = '0;
        txd_last = 1'b0;
        rxd_ready = 1'b0;
        mode = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rxd_valid", rxd_valid, 0);
        chk("rst_rxd_last", rxd_last, 0);
        chk("rst_rxd_data", rxd_data, 0);
        chk("rst_txd_ready", txd_ready, 0);
        chk("rst_beat_count", beat_count, 0);
        chk("rst_pkt_count", pkt_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("tready_pre", txd_ready, 0);
        @(posedge clk);
        #1;
        chk("tready_post", txd_ready, 1);

        mode = 2'd1;
        send({NL{32'hFFFFFFFF}}, 1'b1);
        chk("m1_valid", rxd_valid, 1);
        chk("m1_data", rxd_data, {NL{32'hDEADBEEE}});
        idle(1);
        chk("m1_beat_count", beat_count, 1);
        chk("m1_pkt_count", pkt_count, 1);

        mode = 2'd2;
        send('0, 1'b1);
        chk("m2_lane0", rxd_data[0 +: LW], 0);
        chk("m2_lane15", rxd_data[15*LW +: LW], 30);
        idle(1);
        mode = 2'd3;
        send('0, 1'b1);
        chk("m3_data", rxd_data, {NL{32'h21524111}});
        idle(1);

        mode = 2'd1;
        send({NL{32'h1}}, 1'b0);
        mode = 2'd0;
        send({NL{32'h2}}, 1'b0);
        send({NL{32'h3}}, 1'b0);
        send({NL{32'h4}}, 1'b1);
        chk("latch_beat4", rxd_data, {NL{32'hDEADBEF3}});
        send({NL{32'h55}}, 1'b1);
        chk("pass_next_pkt", rxd_data, {NL{32'h55}});
        drain();

        mode = 2'd2;
        sent = 0;
        acc_low = 0;
        cyc = 0;
        base = exp_beats;
        while (sent < 100 && cyc < 1000) begin
            r = !(cyc >= 40 && cyc < 45);
            drive_cycle(1'b1, {NL{LW'(sent)}}, (sent % 10) == 9, r, acc);
            if (!r && acc) acc_low++;
            if (acc) sent++;
            if (cyc == 42) chk("bp_tready_low", txd_ready, 0);
            cyc++;
        end
        chk("bp_extra_beats", acc_low, 1);
        chk("bp_sent", sent, 100);
        drain();
        chk("bp_out_count", exp_beats - base, 100);

        chk_ready = 1'b1;
        sent = 0;
        cyc = 0;
        d = '0;
        l = 1'b0;
        acc = 1'b1;
        while (sent < 1000 && cyc < 6000) begin
            if (acc) begin
                for (int k = 0; k < NL; k++) d[k*LW +: LW] = $urandom;
                l = ($urandom_range(0, 3) == 0);
            end
            mode = 2'($urandom_range(0, 3));
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            drive_cycle(v, d, l, r, acc);
            if (acc) sent++;
            cyc++;
        end
        chk_ready = 1'b0;
        chk("rnd_sent", sent, 1000);
        drain();

        mode = 2'd1;
        send({NL{32'h7}}, 1'b0);
        cyc = 0;
        acc = 1'b0;
        while (txd_ready && cyc < 10) begin
            drive_cycle(1'b1, {NL{LW'(cyc + 8)}}, 1'b0, 1'b0, acc);
            cyc++;
        end
        chk("full_out_valid", rxd_valid, 1);
        chk("full_tready", txd_ready, 0);
        rst = 1'b1;
        txd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("prst_rxd_valid", rxd_valid, 0);
        chk("prst_beat_count", beat_count, 0);
        chk("prst_pkt_count", pkt_count, 0);
        chk("prst_tready", txd_ready, 0);
        @(posedge clk);
        #1;
        chk("prst_tready_up", txd_ready, 1);
        mode = 2'd2;
        send('0, 1'b1);
        chk("prst_live_mode", rxd_data[15*LW +: LW], 30);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
